// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch slice.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_W_DEF    = 6;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned RESET_PC    = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC priority mux: branch over jump over sequential adder return.
module next_pc_sel #(
  parameter int unsigned PC_W = 6
) (
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] pc_plus,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect
);

  always_comb begin
    redirect = branch_taken | jump;
    if (branch_taken) begin
      next_pc = branch_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else begin
      next_pc = pc_plus;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM (BOOT/FETCH/HOLD), skid buffer and IF/ID stage.
// Optional wrap trap enabled by defining PC_WRAP_TRAP_EN.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = pc_fetch_pkg::RESET_PC,
  parameter int unsigned INSTR_W  = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_step,
  input  logic [PC_W-1:0]    pc_plus,
  input  logic               pc_cout,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus,
  output logic               ifid_valid
`ifdef PC_WRAP_TRAP_EN
  ,
  output logic               pc_wrap_err
`endif
);

`ifdef PC_WRAP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifid_pc_plus_q, ifid_pc_plus_d;
  logic               valid_q, valid_d;
  logic               trap_q, trap_d;

  logic [PC_W-1:0]    next_pc;
  logic               redirect;
  logic               advance;
  logic [INSTR_W-1:0] adv_word;
  logic               wrap_hit;

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc_plus       (pc_plus),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign wrap_hit = TRAP_EN && pc_cout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_BOOT;
      pc_q           <= PC_W'(RESET_PC);
      skid_q         <= '0;
      instr_q        <= '0;
      ifid_pc_plus_q <= '0;
      valid_q        <= 1'b0;
      trap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      skid_q         <= skid_d;
      instr_q        <= instr_d;
      ifid_pc_plus_q <= ifid_pc_plus_d;
      valid_q        <= valid_d;
      trap_q         <= trap_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    skid_d         = skid_q;
    instr_d        = instr_q;
    ifid_pc_plus_d = ifid_pc_plus_q;
    valid_d        = valid_q;
    trap_d         = trap_q;
    advance        = 1'b0;
    adv_word       = imem_rdata;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH, ST_HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          instr_d = INSTR_W'(NOP_INSTR);
          state_d = ST_FETCH;
        end else if (state_q == ST_HOLD) begin
          if (!stall) begin
            advance  = 1'b1;
            adv_word = skid_q;
            state_d  = ST_FETCH;
          end
        end else if (!trap_q) begin
          if (imem_ready && !stall) begin
            advance = 1'b1;
          end else if (imem_ready) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // A trapping wrap drops the completing word and leaves the PC in place.
    if (advance) begin
      if (wrap_hit) begin
        trap_d  = 1'b1;
        valid_d = 1'b0;
      end else begin
        instr_d        = adv_word;
        ifid_pc_plus_d = pc_plus;
        valid_d        = 1'b1;
        pc_d           = next_pc;
      end
    end
  end

  always_comb begin
    imem_req = (state_q == ST_FETCH) && !trap_q;
  end

  assign pc_out       = pc_q;
  assign pc_step      = PC_W'(PC_STEP);
  assign imem_addr    = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc_plus = ifid_pc_plus_q;
  assign ifid_valid   = valid_q;

`ifdef PC_WRAP_TRAP_EN
  assign pc_wrap_err = trap_q;
`endif

endmodule
